// File: rtl/ovf_mon_pkg.sv
// Shared types for the overflow start/handshake protocol monitor.
package ovf_mon_pkg;

    localparam int ERR_W = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FALL = 2'd1,
        LOW       = 2'd2
    } ch_state_e;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_PRE    = 3'd1,
        ERR_EARLY  = 3'd2,
        ERR_LATE   = 3'd3,
        ERR_IEARLY = 3'd4,
        ERR_NOI    = 3'd5,
        ERR_TMO    = 3'd6,
        ERR_RETRIG = 3'd7
    } err_e;

    function automatic logic is_active(input ch_state_e s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/ovf_ch_checker.sv
// One channel of the monitor: edge history, sequence FSM, elapsed/low counters and
// registered pass/fail/err_code/busy outputs.
module ovf_ch_checker
    import ovf_mon_pkg::*;
#(
    parameter int MIN_DLY = 2,
    parameter int MAX_DLY = 20,
    parameter int LOW_MAX = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             start,
    input  logic             i_vof,
    input  logic             o_vof,
    output logic             pass,
    output logic             fail,
    output logic [ERR_W-1:0] err_code,
    output logic             busy
);

    localparam int CNT_BITS  = $clog2(MAX_DLY + 1);
    localparam int LCNT_BITS = (LOW_MAX > 0) ? $clog2(LOW_MAX + 1) : 1;
    localparam logic [CNT_BITS-1:0]  CNT_ONE   = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0]  CNT_FULL  = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0]  MIN_C     = CNT_BITS'(MIN_DLY);
    localparam logic [CNT_BITS-1:0]  MAX_C     = CNT_BITS'(MAX_DLY);
    localparam logic [LCNT_BITS-1:0] LCNT_ONE  = LCNT_BITS'(1);
    localparam logic [LCNT_BITS-1:0] LCNT_FULL = {LCNT_BITS{1'b1}};
    localparam logic [LCNT_BITS-1:0] LMAX_C    = LCNT_BITS'(LOW_MAX);
    localparam logic                 TMO_EN    = (LOW_MAX != 0);

    logic                 hist_vld_r, start_q_r, ivof_q_r, ovof_q_r;
    logic                 start_rise_s, ivof_rise_s, ovof_rise_s, ovof_fell_s;
    ch_state_e            state_r, state_nxt_s;
    logic [CNT_BITS-1:0]  cnt_r, cnt_nxt_s;
    logic [LCNT_BITS-1:0] lcnt_r, lcnt_nxt_s;
    logic                 done_s, pass_s, fail_s, busy_nxt_s;
    err_e                 code_s, err_r, err_nxt_s;
    logic                 pass_r, fail_r, busy_r;

    // Previous-sample history; keeps running while en=0 so re-enabling sees true edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_vld_r <= 1'b0;
            start_q_r  <= 1'b0;
            ivof_q_r   <= 1'b0;
            ovof_q_r   <= 1'b0;
        end else begin
            hist_vld_r <= 1'b1;
            start_q_r  <= start;
            ivof_q_r   <= i_vof;
            ovof_q_r   <= o_vof;
        end
    end

    assign start_rise_s = hist_vld_r & start & ~start_q_r;
    assign ivof_rise_s  = hist_vld_r & i_vof & ~ivof_q_r;
    assign ovof_rise_s  = hist_vld_r & o_vof & ~ovof_q_r;
    assign ovof_fell_s  = hist_vld_r & ~o_vof & ovof_q_r;

    // FSM state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_BITS{1'b0}};
            lcnt_r  <= {LCNT_BITS{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            lcnt_r  <= lcnt_nxt_s;
        end
    end

    // Next-state decision; done_s with code_s==ERR_NONE means the sequence passed
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        lcnt_nxt_s  = lcnt_r;
        done_s      = 1'b0;
        code_s      = ERR_NONE;
        if (!en) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {CNT_BITS{1'b0}};
            lcnt_nxt_s  = {LCNT_BITS{1'b0}};
        end else if (start_rise_s && is_active(state_r)) begin
            // Old sequence is reported, new one is evaluated from this very cycle
            done_s      = 1'b1;
            code_s      = ERR_RETRIG;
            state_nxt_s = o_vof ? WAIT_FALL : IDLE;
            cnt_nxt_s   = CNT_ONE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_rise_s && o_vof) begin
                        state_nxt_s = WAIT_FALL;
                        cnt_nxt_s   = CNT_ONE;
                    end else if (start_rise_s) begin
                        done_s = 1'b1;
                        code_s = ERR_PRE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                WAIT_FALL: begin
                    if (ovof_fell_s && (cnt_r < MIN_C)) begin
                        done_s      = 1'b1;
                        code_s      = ERR_EARLY;
                        state_nxt_s = IDLE;
                    end else if (ovof_fell_s) begin
                        state_nxt_s = LOW;
                        lcnt_nxt_s  = LCNT_ONE;
                    end else if (cnt_r >= MAX_C) begin
                        done_s      = 1'b1;
                        code_s      = ERR_LATE;
                        state_nxt_s = IDLE;
                    end else if (cnt_r != CNT_FULL) begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                LOW: begin
                    if (!o_vof && ivof_rise_s) begin
                        done_s      = 1'b1;
                        code_s      = ERR_IEARLY;
                        state_nxt_s = IDLE;
                    end else if (ovof_rise_s && ivof_rise_s) begin
                        done_s      = 1'b1;
                        state_nxt_s = IDLE;
                    end else if (ovof_rise_s) begin
                        done_s      = 1'b1;
                        code_s      = ERR_NOI;
                        state_nxt_s = IDLE;
                    end else if (TMO_EN && !o_vof && (lcnt_r >= LMAX_C)) begin
                        done_s      = 1'b1;
                        code_s      = ERR_TMO;
                        state_nxt_s = IDLE;
                    end else if (lcnt_r != LCNT_FULL) begin
                        lcnt_nxt_s = lcnt_r + LCNT_ONE;
                    end else begin
                        lcnt_nxt_s = lcnt_r;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Output decode: pulses, sticky error (clr wins) and busy
    always_comb begin
        pass_s = done_s && (code_s == ERR_NONE);
        fail_s = done_s && (code_s != ERR_NONE);
        if (clr) begin
            err_nxt_s = ERR_NONE;
        end else if (fail_s) begin
            err_nxt_s = code_s;
        end else begin
            err_nxt_s = err_r;
        end
        busy_nxt_s = is_active(state_nxt_s);
    end

    // Registered channel outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_r <= 1'b0;
            fail_r <= 1'b0;
            err_r  <= ERR_NONE;
            busy_r <= 1'b0;
        end else begin
            pass_r <= pass_s;
            fail_r <= fail_s;
            err_r  <= err_nxt_s;
            busy_r <= busy_nxt_s;
        end
    end

    assign pass     = pass_r;
    assign fail     = fail_r;
    assign err_code = err_r;
    assign busy     = busy_r;

endmodule

// File: rtl/ovf_seq_monitor.sv
// Multi-channel start/overflow handshake monitor: per-channel checkers plus
// saturating totals of pass and fail pulses.
module ovf_seq_monitor
    import ovf_mon_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MIN_DLY = 2,
    parameter int MAX_DLY = 20,
    parameter int LOW_MAX = 0,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       i_vof,
    input  logic [NUM_CH-1:0]       o_vof,
    output logic [NUM_CH-1:0]       pass,
    output logic [NUM_CH-1:0]       fail,
    output logic [NUM_CH*ERR_W-1:0] err_code,
    output logic [NUM_CH-1:0]       busy,
    output logic [CNT_W-1:0]        pass_cnt,
    output logic [CNT_W-1:0]        fail_cnt
);

    localparam int POP_W = $clog2(NUM_CH + 1);

    logic [POP_W-1:0] pass_pop_s, fail_pop_s;
    logic [CNT_W:0]   pass_sum_s, fail_sum_s;
    logic [CNT_W-1:0] pass_cnt_r, fail_cnt_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ovf_ch_checker #(
            .MIN_DLY (MIN_DLY),
            .MAX_DLY (MAX_DLY),
            .LOW_MAX (LOW_MAX)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .clr      (clr),
            .start    (start[g]),
            .i_vof    (i_vof[g]),
            .o_vof    (o_vof[g]),
            .pass     (pass[g]),
            .fail     (fail[g]),
            .err_code (err_code[g*ERR_W +: ERR_W]),
            .busy     (busy[g])
        );
    end

    // Popcount of this cycle's pulses; the extra sum bit flags saturation
    always_comb begin
        pass_pop_s = {POP_W{1'b0}};
        fail_pop_s = {POP_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            pass_pop_s = pass_pop_s + POP_W'(pass[i]);
            fail_pop_s = fail_pop_s + POP_W'(fail[i]);
        end
        pass_sum_s = {1'b0, pass_cnt_r} + (CNT_W+1)'(pass_pop_s);
        fail_sum_s = {1'b0, fail_cnt_r} + (CNT_W+1)'(fail_pop_s);
    end

    // Saturating totals; clr overrides any pulses present in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_r <= {CNT_W{1'b0}};
            fail_cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            pass_cnt_r <= {CNT_W{1'b0}};
            fail_cnt_r <= {CNT_W{1'b0}};
        end else begin
            pass_cnt_r <= pass_sum_s[CNT_W] ? {CNT_W{1'b1}} : pass_sum_s[CNT_W-1:0];
            fail_cnt_r <= fail_sum_s[CNT_W] ? {CNT_W{1'b1}} : fail_sum_s[CNT_W-1:0];
        end
    end

    assign pass_cnt = pass_cnt_r;
    assign fail_cnt = fail_cnt_r;

endmodule

// File: tb/tb_ovf_seq_monitor.sv
// Bench for ovf_seq_monitor: two instances (unbounded LOW / LOW_MAX=4 with 2-bit counters)
// share directed stimulus and are checked every cycle against a timestamp-based model.
module tb_ovf_seq_monitor;

    localparam int MIN_D = 2;
    localparam int MAX_D = 20;

    logic        clk, rst_n, en, clr;
    logic [3:0]  start, i_vof, o_vof;
    logic [3:0]  pass_a, fail_a, busy_a, pass_b, fail_b, busy_b;
    logic [11:0] err_a, err_b;
    logic [15:0] pcnt_a, fcnt_a;
    logic [1:0]  pcnt_b, fcnt_b;

    int total = 0;
    int bad   = 0;

    ovf_seq_monitor #(.NUM_CH(4), .MIN_DLY(2), .MAX_DLY(20), .LOW_MAX(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .start(start), .i_vof(i_vof),
        .o_vof(o_vof), .pass(pass_a), .fail(fail_a), .err_code(err_a), .busy(busy_a),
        .pass_cnt(pcnt_a), .fail_cnt(fcnt_a));

    ovf_seq_monitor #(.NUM_CH(4), .MIN_DLY(2), .MAX_DLY(20), .LOW_MAX(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .start(start), .i_vof(i_vof),
        .o_vof(o_vof), .pass(pass_b), .fail(fail_b), .err_code(err_b), .busy(busy_b),
        .pass_cnt(pcnt_b), .fail_cnt(fcnt_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: phase 0 idle, 1 waiting for o_vof fall, 2 o_vof low; times are cycle stamps
    int          LM[2]   = '{0, 4};
    int          CMAX[2] = '{65535, 3};
    int          ph[2][4], ts[2][4], tf[2][4];
    logic [3:0]  exp_pass[2], exp_fail[2], exp_busy[2];
    logic [11:0] exp_err[2];
    int          exp_pc[2], exp_fc[2];
    logic [3:0]  prv_s, prv_i, prv_o;
    bit          hv;
    int          ncyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_pass[i] = 4'd0; exp_fail[i] = 4'd0; exp_busy[i] = 4'd0;
            exp_err[i]  = 12'd0; exp_pc[i] = 0; exp_fc[i] = 0;
            for (int c = 0; c < 4; c++) ph[i][c] = 0;
        end
        hv = 1'b0; prv_s = 4'd0; prv_i = 4'd0; prv_o = 4'd0;
    endtask

    task automatic model_update();
        bit rs, ri, ro, fo, p, f;
        logic [2:0] e;
        int el, lo;
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                exp_pc[i] = 0; exp_fc[i] = 0;
            end else begin
                exp_pc[i] = exp_pc[i] + $countones(exp_pass[i]);
                exp_fc[i] = exp_fc[i] + $countones(exp_fail[i]);
                if (exp_pc[i] > CMAX[i]) exp_pc[i] = CMAX[i];
                if (exp_fc[i] > CMAX[i]) exp_fc[i] = CMAX[i];
            end
            for (int c = 0; c < 4; c++) begin
                rs = hv && start[c] && !prv_s[c];
                ri = hv && i_vof[c] && !prv_i[c];
                ro = hv && o_vof[c] && !prv_o[c];
                fo = hv && !o_vof[c] && prv_o[c];
                p = 1'b0; f = 1'b0; e = 3'd0;
                if (!en) begin
                    ph[i][c] = 0;
                end else if (rs && ph[i][c] != 0) begin
                    f = 1'b1; e = 3'd7;
                    ph[i][c] = o_vof[c] ? 1 : 0;
                    ts[i][c] = ncyc;
                end else if (ph[i][c] == 0) begin
                    if (rs && o_vof[c]) begin ph[i][c] = 1; ts[i][c] = ncyc; end
                    else if (rs) begin f = 1'b1; e = 3'd1; end
                end else if (ph[i][c] == 1) begin
                    el = ncyc - ts[i][c];
                    if (fo && el < MIN_D) begin f = 1'b1; e = 3'd2; ph[i][c] = 0; end
                    else if (fo) begin ph[i][c] = 2; tf[i][c] = ncyc; end
                    else if (el >= MAX_D) begin f = 1'b1; e = 3'd3; ph[i][c] = 0; end
                end else begin
                    lo = ncyc - tf[i][c];
                    if (!o_vof[c] && ri) begin f = 1'b1; e = 3'd4; end
                    else if (ro && ri) p = 1'b1;
                    else if (ro) begin f = 1'b1; e = 3'd5; end
                    else if (LM[i] != 0 && lo >= LM[i] && !o_vof[c]) begin f = 1'b1; e = 3'd6; end
                    if (p || f) ph[i][c] = 0;
                end
                exp_pass[i][c] = p;
                exp_fail[i][c] = f;
                if (clr) exp_err[i][c*3 +: 3] = 3'd0;
                else if (f) exp_err[i][c*3 +: 3] = e;
                exp_busy[i][c] = (ph[i][c] != 0);
            end
        end
        prv_s = start; prv_i = i_vof; prv_o = o_vof; hv = 1'b1;
        ncyc++;
    endtask

    // Every cycle: all outputs of both instances against the model
    always @(negedge clk) begin
        chk("a_pass", 32'(pass_a), 32'(exp_pass[0]));
        chk("a_fail", 32'(fail_a), 32'(exp_fail[0]));
        chk("a_busy", 32'(busy_a), 32'(exp_busy[0]));
        chk("a_err",  32'(err_a),  32'(exp_err[0]));
        chk("a_pcnt", 32'(pcnt_a), 32'(exp_pc[0]));
        chk("a_fcnt", 32'(fcnt_a), 32'(exp_fc[0]));
        chk("b_pass", 32'(pass_b), 32'(exp_pass[1]));
        chk("b_fail", 32'(fail_b), 32'(exp_fail[1]));
        chk("b_busy", 32'(busy_b), 32'(exp_busy[1]));
        chk("b_err",  32'(err_b),  32'(exp_err[1]));
        chk("b_pcnt", 32'(pcnt_b), 32'(exp_pc[1]));
        chk("b_fcnt", 32'(fcnt_b), 32'(exp_fc[1]));
    end

    task automatic step();
        @(posedge clk);
        if (rst_n) model_update();
        else model_reset();
        @(negedge clk);
    endtask

    // k=0 is the start-rise cycle; o_vof low on [fall_d, orise_d), i_vof high from irise_d
    task automatic play(input logic [3:0] mask, input int fall_d, input int orise_d,
                        input int irise_d, input int len, input bit en0, input int clr_at);
        for (int k = 0; k < len; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (mask[c]) begin
                    start[c] = (k < 2);
                    o_vof[c] = !(k >= fall_d && k < orise_d);
                    i_vof[c] = (k >= irise_d);
                end
            end
            en  = !(en0 && k == 0);
            clr = (k == clr_at);
            step();
        end
        start = start & ~mask; o_vof = o_vof | mask; i_vof = i_vof & ~mask;
        en = 1'b1; clr = 1'b0;
        step(); step();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; clr = 1'b0;
        start = 4'd0; i_vof = 4'd0; o_vof = 4'hF;
        model_reset();
        step(); step();
        #2 rst_n = 1'b1;
        step(); step(); step();
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_err",  32'(err_a),  32'd0);

        play(4'b0001, 15, 18, 18, 22, 1'b0, -1);            // nominal pass
        chk("lit_pass1", 32'(pcnt_a), 32'd1);
        chk("lit_err_none", 32'(err_a), 32'd0);
        play(4'b0001, 1, 5, 5, 10, 1'b0, -1);               // early fall
        chk("lit_early", 32'(err_a[2:0]), 32'd2);
        play(4'b0001, 30, 30, 30, 24, 1'b0, -1);            // never falls
        chk("lit_late", 32'(err_a[2:0]), 32'd3);
        play(4'b0010, 5, 8, 9, 12, 1'b0, -1);               // i_vof one cycle late
        chk("lit_noi", 32'(err_a[5:3]), 32'd5);
        play(4'b0010, 5, 9, 7, 12, 1'b0, -1);               // i_vof before o_vof
        chk("lit_iearly", 32'(err_a[5:3]), 32'd4);
        play(4'b0100, 0, 3, 3, 6, 1'b0, -1);                // o_vof already low at start
        chk("lit_pre", 32'(err_a[8:6]), 32'd1);
        chk("lit_fcnt5", 32'(fcnt_a), 32'd5);
        play(4'b0101, 4, 7, 7, 10, 1'b0, -1);               // ch0 and ch2 together
        chk("lit_pair", 32'(pcnt_a), 32'd3);

        // Retrigger on ch3 at elapsed 5, second sequence then passes
        for (int k = 0; k < 17; k++) begin
            start[3] = (k < 2) || (k >= 5 && k < 7);
            o_vof[3] = !(k >= 9 && k < 12);
            i_vof[3] = (k >= 12);
            step();
        end
        start[3] = 1'b0; i_vof[3] = 1'b0;
        step(); step();
        chk("lit_retrig", 32'(err_a[11:9]), 32'd7);
        chk("lit_retrig_pcnt", 32'(pcnt_a), 32'd4);
        chk("lit_retrig_fcnt", 32'(fcnt_a), 32'd6);

        play(4'b0001, 3, 9, 9, 12, 1'b0, -1);               // low 6 cycles: TMO only on b
        chk("lit_tmo_b", 32'(err_b[2:0]), 32'd6);
        chk("lit_tmo_a_pass", 32'(pcnt_a), 32'd5);

        play(4'b0001, 15, 18, 18, 22, 1'b0, 19);            // clr coincides with counting
        chk("lit_clr_pcnt", 32'(pcnt_a), 32'd0);
        chk("lit_clr_err", 32'(err_b), 32'd0);

        play(4'b1111, 4, 7, 7, 10, 1'b0, -1);
        play(4'b0001, 4, 7, 7, 10, 1'b0, -1);
        chk("lit_sat_b", 32'(pcnt_b), 32'd3);
        chk("lit_sat_a", 32'(pcnt_a), 32'd5);
        clr = 1'b1; step(); clr = 1'b0;
        chk("lit_sat_clr", 32'(pcnt_b), 32'd0);
        step();

        play(4'b0001, 4, 7, 7, 10, 1'b1, -1);               // en low at start rise
        chk("lit_en0", 32'(pcnt_a), 32'd0);

        // Async reset in the middle of WAIT_FALL
        start[0] = 1'b1;
        step(); step(); step();
        chk("lit_busy_pre_rst", 32'(busy_a[0]), 32'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk("lit_busy_rst", 32'(busy_a), 32'd0);
        start[0] = 1'b0;
        step(); step();
        #2 rst_n = 1'b1;
        step();
        o_vof[0] = 1'b0; step(); step();
        o_vof[0] = 1'b1; i_vof[0] = 1'b1; step(); step();
        i_vof[0] = 1'b0; step();
        chk("lit_rst_nopulse", 32'(fcnt_a) + 32'(pcnt_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
